// File: rtl/board_move_writer_if.sv
// Move request / board status bundle between turn control, the board writer
// and the win decoder. The writer sits on the slave side; the requester is the master.
interface board_move_writer_if #(
  parameter int unsigned ROWS = 6,
  parameter int unsigned COLS = 7
);
  localparam int unsigned Cells = ROWS * COLS;

  logic             move_valid;
  logic             move_ready;
  logic [2:0]       move_col;
  logic             player_in;
  logic [Cells-1:0] player_register;
  logic [Cells-1:0] onoff_register;
  logic             done_valid;
  logic [2:0]       done_location;
  logic [2:0]       done_height;
  logic             done_player;
  logic             illegal;
  logic             board_full;

  modport master (
    output move_valid, move_col, player_in,
    input  move_ready, player_register, onoff_register, done_valid, done_location,
           done_height, done_player, illegal, board_full
  );

  modport slave (
    input  move_valid, move_col, player_in,
    output move_ready, player_register, onoff_register, done_valid, done_location,
           done_height, done_player, illegal, board_full
  );
endinterface

// File: rtl/board_move_writer.sv
// Board writer: owns the onoff/player board registers, accepts one column drop at a
// time, scans the column bottom-up for the first free cell and writes the piece there.
// Optional feature macro: TURN_CHECK_EN (reject a move by the player who moved last).
module board_move_writer #(
  parameter int unsigned ROWS = 6,
  parameter int unsigned COLS = 7
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 clear_i,
  board_move_writer_if.slave   mv
);
  localparam int unsigned Cells = ROWS * COLS;
  localparam int unsigned IdxW  = 6;
  localparam logic [IdxW-1:0] RowsW = IdxW'(ROWS);
  localparam logic [2:0]      TopH  = 3'(ROWS - 1);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StScan   = 3'd1;
  localparam logic [2:0] StWrite  = 3'd2;
  localparam logic [2:0] StDone   = 3'd3;
  localparam logic [2:0] StReject = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [2:0]       height_q, height_d;
  logic [2:0]       col_q, col_d;
  logic             player_q, player_d;
  logic [Cells-1:0] onoff_q, onoff_d;
  logic [Cells-1:0] owner_q, owner_d;
  logic             done_valid_q;
  logic [2:0]       done_loc_q;
  logic [2:0]       done_h_q;
  logic             done_player_q;
  logic             illegal_q;
  logic             full_q;
  logic             accept;
  logic             bad_col;
  logic             turn_bad;
  logic [IdxW-1:0]  idx;

`ifdef TURN_CHECK_EN
  logic last_player_q, last_player_d;
  assign turn_bad = (mv.player_in == last_player_q);
`else
  assign turn_bad = 1'b0;
`endif

  assign mv.move_ready = (state_q == StIdle) & ~clear_i;
  assign accept        = mv.move_valid & mv.move_ready;
  assign bad_col       = (32'(mv.move_col) >= COLS);
  // Only meaningful in SCAN/WRITE, where col_q is known to be in range.
  assign idx           = IdxW'(col_q) * RowsW + IdxW'(height_q);

  // Next-state logic: FSM, scan height, latched request and board updates.
  always_comb begin
    state_d  = state_q;
    height_d = height_q;
    col_d    = col_q;
    player_d = player_q;
    onoff_d  = onoff_q;
    owner_d  = owner_q;
`ifdef TURN_CHECK_EN
    last_player_d = last_player_q;
`endif
    if (clear_i) begin
      state_d  = StIdle;
      height_d = 3'd0;
      onoff_d  = '0;
      owner_d  = '0;
`ifdef TURN_CHECK_EN
      last_player_d = 1'b1;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            col_d    = mv.move_col;
            player_d = mv.player_in;
            height_d = 3'd0;
            state_d  = (bad_col || turn_bad) ? StReject : StScan;
          end
        end
        StScan: begin
          if (!onoff_q[idx]) begin
            state_d = StWrite;
          end else if (height_q == TopH) begin
            state_d = StReject;
          end else begin
            height_d = height_q + 3'd1;
          end
        end
        StWrite: begin
          onoff_d[idx] = 1'b1;
          owner_d[idx] = player_q;
`ifdef TURN_CHECK_EN
          last_player_d = player_q;
`endif
          state_d = StDone;
        end
        StDone:   state_d = StIdle;
        StReject: state_d = StIdle;
        default:  state_d = StIdle;
      endcase
    end
  end

  // State registers; pulses are registered from DONE/REJECT so they follow those states.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= StIdle;
      height_q      <= 3'd0;
      col_q         <= 3'd0;
      player_q      <= 1'b0;
      onoff_q       <= '0;
      owner_q       <= '0;
      done_valid_q  <= 1'b0;
      done_loc_q    <= 3'd0;
      done_h_q      <= 3'd0;
      done_player_q <= 1'b0;
      illegal_q     <= 1'b0;
      full_q        <= 1'b0;
`ifdef TURN_CHECK_EN
      last_player_q <= 1'b1;
`endif
    end else begin
      state_q      <= state_d;
      height_q     <= height_d;
      col_q        <= col_d;
      player_q     <= player_d;
      onoff_q      <= onoff_d;
      owner_q      <= owner_d;
      done_valid_q <= ~clear_i & (state_q == StDone);
      illegal_q    <= ~clear_i & (state_q == StReject);
      full_q       <= ~clear_i & (&onoff_q);
      if (!clear_i && state_q == StDone) begin
        done_loc_q    <= col_q;
        done_h_q      <= height_q;
        done_player_q <= player_q;
      end
`ifdef TURN_CHECK_EN
      last_player_q <= last_player_d;
`endif
    end
  end

  assign mv.onoff_register  = onoff_q;
  assign mv.player_register = owner_q;
  assign mv.done_valid      = done_valid_q;
  assign mv.done_location   = done_loc_q;
  assign mv.done_height     = done_h_q;
  assign mv.done_player     = done_player_q;
  assign mv.illegal         = illegal_q;
  assign mv.board_full      = full_q;
endmodule

// File: tb/tb_board_move_writer.sv
// Directed bench for board_move_writer: latency, landing cell, full column, bad column,
// full board, clear and reset mid-move, and turn enforcement (TURN_CHECK_EN).
module tb_board_move_writer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  board_move_writer_if mv ();

  board_move_writer dut (
    .clock_i (clk),
    .reset_i (rst),
    .clear_i (clr),
    .mv      (mv)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one drop and wait (bounded) for done or illegal; lat counts edges after accept.
  task automatic drop(input int col, input bit p, output int lat, output bit ok,
                      output bit bad);
    @(negedge clk);
    mv.move_valid = 1'b1;
    mv.move_col   = 3'(col);
    mv.player_in  = p;
    @(posedge clk);
    #1 mv.move_valid = 1'b0;
    lat = 0;
    ok  = 1'b0;
    bad = 1'b0;
    while (lat < 20 && !ok && !bad) begin
      @(posedge clk);
      #1;
      lat++;
      ok  = mv.done_valid;
      bad = mv.illegal;
    end
    check("drop_ends", 64'(ok | bad), 64'd1);
  endtask

  task automatic clear_board();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  // Watch n cycles for any done/illegal pulse.
  task automatic watch_quiet(input string tag, input int n);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1 seen = seen | mv.done_valid | mv.illegal;
    end
    check(tag, 64'(seen), 64'd0);
  endtask

  int   lat;
  bit   ok, bad;
  logic [41:0] exp_on, exp_pl;

  initial begin
    mv.move_valid = 1'b0;
    mv.move_col   = 3'd0;
    mv.player_in  = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_onoff", 64'(mv.onoff_register), 64'd0);
    check("rst_player", 64'(mv.player_register), 64'd0);
    check("rst_done", 64'(mv.done_valid), 64'd0);
    check("rst_illegal", 64'(mv.illegal), 64'd0);
    check("rst_full", 64'(mv.board_full), 64'd0);
    check("rst_loc", 64'(mv.done_location), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("idle_ready", 64'(mv.move_ready), 64'd1);

    // 1: empty board, column 3, player 1
    drop(3, 1'b1, lat, ok, bad);
    check("t1_lat", 64'(lat), 64'd3);
    check("t1_done", 64'(ok), 64'd1);
    check("t1_loc", 64'(mv.done_location), 64'd3);
    check("t1_h", 64'(mv.done_height), 64'd0);
    check("t1_pl", 64'(mv.done_player), 64'd1);
    check("t1_onoff", 64'(mv.onoff_register), 64'(42'd1 << 18));
    check("t1_player", 64'(mv.player_register), 64'(42'd1 << 18));

    // 2: column 0 holding 4 pieces (players 0,1,0,1), drop player 0 lands at h=4
    clear_board();
    for (int i = 0; i < 4; i++) drop(0, 1'(i % 2), lat, ok, bad);
    drop(0, 1'b0, lat, ok, bad);
    check("t2_lat", 64'(lat), 64'd7);
    check("t2_done", 64'(ok), 64'd1);
    check("t2_h", 64'(mv.done_height), 64'd4);
    check("t2_loc", 64'(mv.done_location), 64'd0);
    check("t2_onoff", 64'(mv.onoff_register), 64'h1f);
    check("t2_player", 64'(mv.player_register), 64'h0a);

    // 3: full column 6, then out-of-range column 7
    clear_board();
    for (int i = 0; i < 6; i++) drop(6, 1'(i % 2), lat, ok, bad);
    exp_on = 42'h3f << 36;
    exp_pl = 42'h2a << 36;
    check("t3_fill_on", 64'(mv.onoff_register), 64'(exp_on));
    check("t3_fill_pl", 64'(mv.player_register), 64'(exp_pl));
    drop(6, 1'b0, lat, ok, bad);
    check("t3_lat", 64'(lat), 64'd7);
    check("t3_illegal", 64'(bad), 64'd1);
    check("t3_onoff", 64'(mv.onoff_register), 64'(exp_on));
    check("t3_player", 64'(mv.player_register), 64'(exp_pl));
    drop(7, 1'b1, lat, ok, bad);
    check("t3_col7_lat", 64'(lat), 64'd1);
    check("t3_col7_ill", 64'(bad), 64'd1);
    check("t3_col7_on", 64'(mv.onoff_register), 64'(exp_on));

    // 4: fill all 42 cells
    clear_board();
    for (int c = 0; c < 7; c++) begin
      for (int h = 0; h < 6; h++) begin
        if (c == 6 && h == 5) check("t4_not_full", 64'(mv.board_full), 64'd0);
        drop(c, 1'(h % 2), lat, ok, bad);
        check("t4_landed", 64'(ok), 64'd1);
      end
    end
    check("t4_full", 64'(mv.board_full), 64'd1);
    check("t4_onoff", 64'(mv.onoff_register), 64'h3ff_ffff_ffff);
    check("t4_player", 64'(mv.player_register), 64'h2aa_aaaa_aaaa);
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    check("t4_clr_on", 64'(mv.onoff_register), 64'd0);
    check("t4_clr_pl", 64'(mv.player_register), 64'd0);
    check("t4_clr_full", 64'(mv.board_full), 64'd0);

    // 5a: clear while scanning
    drop(1, 1'b0, lat, ok, bad);
    check("t5_pre_on", 64'(mv.onoff_register), 64'(42'd1 << 6));
    @(negedge clk);
    mv.move_valid = 1'b1;
    mv.move_col   = 3'd2;
    mv.player_in  = 1'b1;
    @(posedge clk);
    #1 mv.move_valid = 1'b0;
    @(negedge clk);
    clr = 1'b1;
    #1 check("t5_ready_clr", 64'(mv.move_ready), 64'd0);
    @(posedge clk);
    #1 check("t5_clr_on", 64'(mv.onoff_register), 64'd0);
    @(negedge clk);
    clr = 1'b0;
    watch_quiet("t5_clr_quiet", 6);
    check("t5_clr_ready", 64'(mv.move_ready), 64'd1);
    check("t5_clr_on2", 64'(mv.onoff_register), 64'd0);

    // 5b: reset pulsed while in WRITE
    drop(1, 1'b0, lat, ok, bad);
    @(negedge clk);
    mv.move_valid = 1'b1;
    mv.move_col   = 3'd4;
    mv.player_in  = 1'b1;
    @(posedge clk);
    #1 mv.move_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("t5_rst_on", 64'(mv.onoff_register), 64'd0);
    check("t5_rst_pl", 64'(mv.player_register), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    watch_quiet("t5_rst_quiet", 6);
    check("t5_rst_on2", 64'(mv.onoff_register), 64'd0);
    check("t5_rst_ready", 64'(mv.move_ready), 64'd1);

    // 6: player 0 twice in a row
    clear_board();
    drop(5, 1'b0, lat, ok, bad);
    check("t6_first", 64'(ok), 64'd1);
    check("t6_first_h", 64'(mv.done_height), 64'd0);
    drop(5, 1'b0, lat, ok, bad);
`ifdef TURN_CHECK_EN
    check("t6_second_ill", 64'(bad), 64'd1);
    check("t6_on", 64'(mv.onoff_register), 64'(42'd1 << 30));
`else
    check("t6_second_ok", 64'(ok), 64'd1);
    check("t6_second_h", 64'(mv.done_height), 64'd1);
    check("t6_on", 64'(mv.onoff_register), 64'(42'd3 << 30));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
